// File: rtl/md_issue_ctrl.sv
// EX-stage sequencer for MIPS multiply/divide: runs MULT/MULTU internally, drives the
// external divider handshake for DIV/DIVU, and owns the architectural HI/LO pair.
module md_issue_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int OP_W       = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [OP_W-1:0] ex_op,
  input  logic [31:0]     ex_rs_data,
  input  logic [31:0]     ex_rt_data,
  output logic            stall_req,
  output logic            div_start,
  output logic            div_unsigned,
  output logic [31:0]     div_opa,
  output logic [31:0]     div_opb,
  input  logic [63:0]     div_result,
  input  logic            div_done,
  output logic [31:0]     hi,
  output logic [31:0]     lo
);

  localparam logic [OP_W-1:0] OP_MULT  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MULTU = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(6);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] mul_cnt;
  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic             mul_signed;

  logic             is_mul;
  logic             is_div;
  logic             is_mthi;
  logic             is_mtlo;
  logic [63:0]      mul_a_ext;
  logic [63:0]      mul_b_ext;
  logic [63:0]      product;

  always_comb begin
    is_mul  = ex_valid && ((ex_op == OP_MULT) || (ex_op == OP_MULTU));
    is_div  = ex_valid && ((ex_op == OP_DIV)  || (ex_op == OP_DIVU));
    is_mthi = ex_valid && (ex_op == OP_MTHI);
    is_mtlo = ex_valid && (ex_op == OP_MTLO);
  end

  // Low 64 bits of the extended-operand product equal the signed product for MULT.
  assign mul_a_ext = {{32{mul_signed & mul_a[31]}}, mul_a};
  assign mul_b_ext = {{32{mul_signed & mul_b[31]}}, mul_b};
  assign product   = mul_a_ext * mul_b_ext;

  // In IDLE the stall must appear in the accept cycle itself, so it is combinational there.
  always_comb begin
    stall_req = 1'b0;
    case (state)
      IDLE:               stall_req = !flush && (is_mul || is_div);
      MUL_BUSY, DIV_BUSY: stall_req = 1'b1;
      default:            stall_req = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      mul_cnt      <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      mul_signed   <= 1'b0;
      div_start    <= 1'b0;
      div_unsigned <= 1'b0;
      div_opa      <= '0;
      div_opb      <= '0;
      hi           <= '0;
      lo           <= '0;
    end else if (flush) begin
      // Cancels any operation, including one completing this very cycle.
      state     <= IDLE;
      mul_cnt   <= '0;
      div_start <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mul) begin
            mul_a      <= ex_rs_data;
            mul_b      <= ex_rt_data;
            mul_signed <= (ex_op == OP_MULT);
            mul_cnt    <= MUL_LOAD;
            state      <= MUL_BUSY;
          end else if (is_div) begin
            div_opa      <= ex_rs_data;
            div_opb      <= ex_rt_data;
            div_unsigned <= (ex_op == OP_DIVU);
            div_start    <= 1'b1;
            state        <= DIV_BUSY;
          end else if (is_mthi) begin
            hi <= ex_rs_data;
          end else if (is_mtlo) begin
            lo <= ex_rs_data;
          end
        end
        MUL_BUSY: begin
          if (mul_cnt != '0) begin
            mul_cnt <= mul_cnt - 1'b1;
          end else begin
            hi    <= product[63:32];
            lo    <= product[31:0];
            state <= DONE;
          end
        end
        DIV_BUSY: begin
          if (div_done) begin
            hi        <= div_result[63:32];
            lo        <= div_result[31:0];
            div_start <= 1'b0;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Randomized bench for md_issue_ctrl with a 36-cycle divider model and a
// transaction-level HI/LO/stall reference checked every cycle.
module tb_md_issue_ctrl;
  localparam int MUL_CYCLES = 2;
  localparam int OP_W       = 3;
  localparam int DIV_LAT    = 36;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic        stall_req;
  logic        div_start;
  logic        div_unsigned;
  logic [31:0] div_opa;
  logic [31:0] div_opb;
  logic [63:0] div_result;
  logic        div_done;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clock = ~clock;

  md_issue_ctrl #(.MUL_CYCLES(MUL_CYCLES), .OP_W(OP_W)) dut (
    .clock(clock), .reset(reset), .flush(flush), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .stall_req(stall_req),
    .div_start(div_start), .div_unsigned(div_unsigned), .div_opa(div_opa), .div_opb(div_opb),
    .div_result(div_result), .div_done(div_done), .hi(hi), .lo(lo)
  );

  // MIPS division: quotient truncates toward zero, remainder takes the dividend's sign.
  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input logic uns);
    logic signed [31:0] x, y, q, r;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (uns) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
    x = a; y = b;
    q = x / y;
    r = x % y;
    return {r, q};
  endfunction

  // Divider: done pulses in the DIV_LAT-th consecutive cycle of start high.
  int div_cnt = 0;
  always @(posedge clock) begin
    if (div_start !== 1'b1) div_cnt <= 0;
    else                    div_cnt <= div_cnt + 1;
  end
  assign div_done   = (div_start === 1'b1) && (div_cnt == DIV_LAT - 1);
  assign div_result = div_ref(div_opa, div_opb, div_unsigned);

  int   total = 0;
  int   bad = 0;
  int   stall_seen = 0;
  bit   chk_en = 1'b0;
  logic exp_stall = 1'b0;
  logic exp_dstart = 1'b0;
  logic exp_duns = 1'b0;
  logic [31:0] exp_dopa = '0, exp_dopb = '0, exp_hi = '0, exp_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      if (stall_req === 1'b1) stall_seen <= stall_seen + 1;
      check("stall_req", 64'(stall_req), 64'(exp_stall));
      check("div_start", 64'(div_start), 64'(exp_dstart));
      check("hi", 64'(hi), 64'(exp_hi));
      check("lo", 64'(lo), 64'(exp_lo));
      if (exp_dstart) begin
        check("div_opa", 64'(div_opa), 64'(exp_dopa));
        check("div_opb", 64'(div_opb), 64'(exp_dopb));
        check("div_unsigned", 64'(div_unsigned), 64'(exp_duns));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One instruction held in EX until it leaves; flush_at is the cycle index of a flush, -1 for none.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int flush_at);
    bit md, dv, uns;
    int lat;
    logic [63:0] res;
    logic signed [63:0] sa, sb;
    md  = (op >= 3'd1) && (op <= 3'd4);
    dv  = (op == 3'd3) || (op == 3'd4);
    uns = (op == 3'd2) || (op == 3'd4);
    lat = dv ? DIV_LAT + 1 : MUL_CYCLES + 1;
    sa = $signed(a);
    sb = $signed(b);
    if (op == 3'd1)      res = sa * sb;
    else if (op == 3'd2) res = {32'd0, a} * {32'd0, b};
    else                 res = div_ref(a, b, uns);
    $display("txn t=%0t op=%0d a=%h b=%h flush_at=%0d", $time, op, a, b, flush_at);
    ex_valid = 1'b1; ex_op = op; ex_rs_data = a; ex_rt_data = b;
    if (!md) begin
      flush = (flush_at == 0);
      exp_stall = 1'b0; exp_dstart = 1'b0;
      step();
      flush = 1'b0;
      if (flush_at != 0) begin
        if (op == 3'd5) exp_hi = a;
        else if (op == 3'd6) exp_lo = a;
      end
      return;
    end
    for (int k = 0; k <= lat; k++) begin
      flush = (k == flush_at);
      exp_stall  = (k < lat) && !(k == 0 && flush);
      exp_dstart = dv && (k >= 1) && (k <= DIV_LAT);
      exp_dopa = a; exp_dopb = b; exp_duns = uns;
      if (k == lat) begin
        exp_hi = res[63:32];
        exp_lo = res[31:0];
      end
      step();
      if (flush) begin
        flush = 1'b0; ex_valid = 1'b0; exp_stall = 1'b0; exp_dstart = 1'b0;
        return;
      end
    end
    exp_stall = 1'b0; exp_dstart = 1'b0; ex_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    ex_valid = 1'b0; ex_op = 3'($urandom_range(0, 7));
    flush = ($urandom_range(0, 3) == 0);
    exp_stall = 1'b0; exp_dstart = 1'b0;
    $display("txn t=%0t idle flush=%0d", $time, flush);
    step();
    flush = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int s0, lat_r, fa;
    logic [2:0] op;
    reset = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_op = '0; ex_rs_data = '0; ex_rt_data = '0;
    repeat (3) step();
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_opa", 64'(div_opa), 64'd0);
    check("rst_opb", 64'(div_opb), 64'd0);
    check("rst_uns", 64'(div_unsigned), 64'd0);
    step();

    s0 = stall_seen;
    issue(3'd3, 32'hFFFFFFF9, 32'd2, -1);
    check("div_stall_len", 64'(stall_seen - s0), 64'd37);
    check("div_lo", 64'(lo), 64'hFFFFFFFD);
    check("div_hi", 64'(hi), 64'hFFFFFFFF);

    issue(3'd4, 32'hFFFFFFF9, 32'd2, -1);
    check("divu_lo", 64'(lo), 64'h7FFFFFFC);
    check("divu_hi", 64'(hi), 64'h1);

    s0 = stall_seen;
    issue(3'd1, 32'hFFFFFFFF, 32'd2, -1);
    check("mul_stall_len", 64'(stall_seen - s0), 64'd3);
    check("mult_hilo", {32'(hi), 32'(lo)}, 64'hFFFFFFFF_FFFFFFFE);
    issue(3'd2, 32'hFFFFFFFF, 32'd2, -1);
    check("multu_hilo", {32'(hi), 32'(lo)}, 64'h00000001_FFFFFFFE);

    issue(3'd3, 32'd100, 32'd7, DIV_LAT);
    check("flushdiv_hilo", {32'(hi), 32'(lo)}, 64'h00000001_FFFFFFFE);
    issue(3'd3, 32'd10, 32'd3, -1);
    check("div10_3_lo", 64'(lo), 64'd3);
    check("div10_3_hi", 64'(hi), 64'd1);

    issue(3'd5, 32'h12345678, 32'd0, -1);
    issue(3'd6, 32'h9ABCDEF0, 32'd0, -1);
    check("mthi", 64'(hi), 64'h12345678);
    check("mtlo", 64'(lo), 64'h9ABCDEF0);
    issue(3'd5, 32'hDEADBEEF, 32'd0, 0);
    check("mthi_flush", 64'(hi), 64'h12345678);

    // Reset held two cycles while a division is in flight.
    $display("txn t=%0t div then reset mid-busy", $time);
    ex_valid = 1'b1; ex_op = 3'd3; ex_rs_data = 32'd50; ex_rt_data = 32'd5;
    exp_stall = 1'b1; exp_dstart = 1'b0;
    exp_dopa = 32'd50; exp_dopb = 32'd5; exp_duns = 1'b0;
    step();
    exp_dstart = 1'b1;
    repeat (10) step();
    chk_en = 1'b0; ex_valid = 1'b0; reset = 1'b1;
    step(); step();
    reset = 1'b0;
    exp_stall = 1'b0; exp_dstart = 1'b0; exp_hi = '0; exp_lo = '0;
    chk_en = 1'b1;
    check("rst_mid_start", 64'(div_start), 64'd0);
    check("rst_mid_hilo", {32'(hi), 32'(lo)}, 64'd0);
    step();

    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle_cycle();
      end else begin
        op = 3'($urandom_range(0, 7));
        lat_r = (op == 3'd3 || op == 3'd4) ? DIV_LAT + 1 :
                (op == 3'd1 || op == 3'd2) ? MUL_CYCLES + 1 : 0;
        fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, lat_r)) : -1;
        issue(op, pick(), pick(), fa);
      end
    end

    ex_valid = 1'b0; flush = 1'b0; exp_stall = 1'b0; exp_dstart = 1'b0;
    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- EX-stage sequencer for MIPS multiply/divide: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Latches operands and runs an internal multi-cycle multiply, or drives the external iterative divider's start/done handshake.
- Stalls the pipeline while busy and owns the architectural HI/LO registers.
- Sits between the EX decode output and the divider wrapper; MFHI/MFLO read the hi/lo outputs.

Parameters:
- MUL_CYCLES, 2: busy cycles of the multiply path (≥1).
- OP_W, 3: width of the ex_op encoding.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  exception/pipeline flush; cancels any operation in progress
- ex_valid  in  1  EX holds a valid instruction
- ex_op  in  OP_W  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, others NONE
- ex_rs_data  in  32  rs operand (dividend / multiplicand / MTHI/MTLO source)
- ex_rt_data  in  32  rt operand (divisor / multiplier)
- stall_req  out  1  hold IF..EX this cycle
- div_start  out  1  divider start; held high for the whole division
- div_unsigned  out  1  divider unsigned flag
- div_opa  out  32  dividend to divider
- div_opb  out  32  divisor to divider
- div_result  in  64  {remainder, quotient} from divider
- div_done  in  1  divider completion, one-cycle pulse
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Clock and reset: one clock, clock. reset is synchronous and active-high; it wins over all other inputs.
- Reset values: state IDLE; hi=lo=0; div_start=0; div_unsigned=0; div_opa=div_opb=0; stall_req=0; multiply counter 0.
- States: IDLE, MUL_BUSY, DIV_BUSY, DONE.
- IDLE, ex_valid, no flush:
  - MULT/MULTU: latch rs, rt and the signedness; load counter with MUL_CYCLES-1; go to MUL_BUSY.
  - DIV/DIVU: at this edge load div_opa=rs, div_opb=rt, div_unsigned=(op==DIVU) and set div_start=1; go to DIV_BUSY.
  - MTHI: hi<=rs. MTLO: lo<=rs. Stay in IDLE, no stall.
- stall_req in IDLE: combinational, equal to ex_valid & !flush & op∈{MULT,MULTU,DIV,DIVU}.
- stall_req is 1 in MUL_BUSY and DIV_BUSY, and 0 in DONE.
- MUL_BUSY: when the counter is nonzero, decrement it. When it is 0:
  - {hi,lo} <= 64-bit product; MULT sign-extends both operands to 64 bits, MULTU zero-extends.
  - Go to DONE.
- DIV_BUSY: div_start stays 1, and div_opa/div_opb/div_unsigned stay stable. On div_done:
  - hi<=div_result[63:32] (remainder), lo<=div_result[31:0] (quotient).
  - Clear div_start at the same edge, so the divider never restarts.
  - Go to DONE.
- Divide by zero: no special handling; whatever the divider returns is written.
- DONE: one cycle, stall released. The EX instruction advances at the end of this cycle and is not re-issued. Next state IDLE.
- flush (no reset):
  - From any state: go to IDLE, div_start<=0, counter cleared, no HI/LO write.
  - flush in the same cycle as div_done, or as the final MUL_BUSY cycle: flush wins, HI/LO unchanged.
  - flush in IDLE with an MTHI/MTLO: no write.
- Latency, with a 36-cycle divider (done in the 36th cycle of start high):
  - Divide: stall_req high 37 consecutive cycles (accept + 36 busy); HI/LO are visible in the DONE cycle.
  - Multiply: stall_req high MUL_CYCLES+1 cycles.
- Back-to-back: an op presented the cycle after DONE is accepted normally. div_start is low for at least one cycle between divisions, because DONE is in between.

Test Plan:
- reset held 2 cycles mid-DIV_BUSY -> next cycle: state IDLE, div_start=0, hi=lo=0, stall_req=0.
- DIV rs=-7 (0xFFFFFFF9), rt=2, 36-cycle divider model -> stall_req high exactly 37 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; div_start falls on the div_done edge.
- DIVU rs=0xFFFFFFF9, rt=2 -> lo=0x7FFFFFFC, hi=1; div_unsigned=1 throughout.
- MULT 0xFFFFFFFF×2 -> {hi,lo}=0xFFFFFFFF_FFFFFFFE; MULTU same operands -> 0x00000001_FFFFFFFE; stall_req high 3 cycles (MUL_CYCLES=2).
- DIV with flush asserted on the div_done cycle -> hi/lo unchanged, IDLE next cycle; a following DIV 10/3 yields lo=3, hi=1.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles, no stall -> hi=0x12345678, lo=0x9ABCDEF0; MTHI with flush -> hi unchanged.
